// File: rtl/fu_arbiter.sv
// Two-requester arbiter for a shared combinational function unit: grant in IDLE,
// one EXEC cycle, then hold the response in RESP until RSP_READY (3 cycles/op best case).
module fu_arbiter #(
   parameter int DW = 8
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          REQ0_VALID,
   output logic          REQ0_READY,
   input  logic [4:0]    REQ0_FS,
   input  logic [DW-1:0] REQ0_A,
   input  logic [DW-1:0] REQ0_B,
   input  logic          REQ1_VALID,
   output logic          REQ1_READY,
   input  logic [4:0]    REQ1_FS,
   input  logic [DW-1:0] REQ1_A,
   input  logic [DW-1:0] REQ1_B,
   output logic [4:0]    FU_FS,
   output logic [DW-1:0] FU_A,
   output logic [DW-1:0] FU_B,
   input  logic [DW-1:0] FU_F,
   input  logic          FU_V,
   input  logic          FU_C,
   input  logic          FU_N,
   input  logic          FU_Z,
   output logic          RSP_VALID,
   input  logic          RSP_READY,
   output logic          RSP_ID,
   output logic [DW-1:0] RSP_F,
   output logic [3:0]    RSP_FLAGS,
   output logic          RSP_ERR,
   output logic          BUSY,
   output logic [7:0]    OP_CNT
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t        state_q, state_d;
   logic          pri_q, pri_d;
   logic          id_q, id_d;
   logic [4:0]    fs_q, fs_d;
   logic [DW-1:0] a_q, a_d;
   logic [DW-1:0] b_q, b_d;
   logic          rsp_id_q, rsp_id_d;
   logic [DW-1:0] rsp_f_q, rsp_f_d;
   logic [3:0]    rsp_flags_q, rsp_flags_d;
   logic          rsp_err_q, rsp_err_d;
   logic [7:0]    op_cnt_q, op_cnt_d;
   logic          gnt0, gnt1;
   logic          fs_legal;

   always_comb begin
      fs_legal = (fs_q <= 5'd8) || (fs_q == 5'd10) || (fs_q == 5'd12) ||
                 (fs_q == 5'd14) || (fs_q == 5'd16) || (fs_q == 5'd20) ||
                 (fs_q == 5'd24);
   end

   always_comb begin
      state_d     = state_q;
      pri_d       = pri_q;
      id_d        = id_q;
      fs_d        = fs_q;
      a_d         = a_q;
      b_d         = b_q;
      rsp_id_d    = rsp_id_q;
      rsp_f_d     = rsp_f_q;
      rsp_flags_d = rsp_flags_q;
      rsp_err_d   = rsp_err_q;
      op_cnt_d    = op_cnt_q;
      gnt0        = 1'b0;
      gnt1        = 1'b0;

      case (state_q)
         IDLE: begin
            // Gated by RST_N so no requester sees an accept while reset is held.
            if (RST_N) begin
               gnt0 = REQ0_VALID && (!REQ1_VALID || !pri_q);
               gnt1 = REQ1_VALID && (!REQ0_VALID || pri_q);
            end
            if (gnt0) begin
               id_d    = 1'b0;
               fs_d    = REQ0_FS;
               a_d     = REQ0_A;
               b_d     = REQ0_B;
               state_d = EXEC;
            end else if (gnt1) begin
               id_d    = 1'b1;
               fs_d    = REQ1_FS;
               a_d     = REQ1_A;
               b_d     = REQ1_B;
               state_d = EXEC;
            end
         end
         EXEC: begin
            rsp_id_d = id_q;
            if (fs_legal) begin
               rsp_f_d     = FU_F;
               rsp_flags_d = {FU_V, FU_C, FU_N, FU_Z};
               rsp_err_d   = 1'b0;
            end else begin
               rsp_f_d     = '0;
               rsp_flags_d = 4'b0000;
               rsp_err_d   = 1'b1;
            end
            state_d = RESP;
         end
         RESP: begin
            if (RSP_READY) begin
               pri_d    = ~rsp_id_q;
               op_cnt_d = op_cnt_q + 8'd1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q     <= IDLE;
         pri_q       <= 1'b0;
         id_q        <= 1'b0;
         fs_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         rsp_id_q    <= 1'b0;
         rsp_f_q     <= '0;
         rsp_flags_q <= '0;
         rsp_err_q   <= 1'b0;
         op_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         pri_q       <= pri_d;
         id_q        <= id_d;
         fs_q        <= fs_d;
         a_q         <= a_d;
         b_q         <= b_d;
         rsp_id_q    <= rsp_id_d;
         rsp_f_q     <= rsp_f_d;
         rsp_flags_q <= rsp_flags_d;
         rsp_err_q   <= rsp_err_d;
         op_cnt_q    <= op_cnt_d;
      end
   end

   assign REQ0_READY = gnt0;
   assign REQ1_READY = gnt1;
   assign FU_FS      = fs_q;
   assign FU_A       = a_q;
   assign FU_B       = b_q;
   assign RSP_VALID  = (state_q == RESP);
   assign RSP_ID     = rsp_id_q;
   assign RSP_F      = rsp_f_q;
   assign RSP_FLAGS  = rsp_flags_q;
   assign RSP_ERR    = rsp_err_q;
   assign BUSY       = (state_q != IDLE);
   assign OP_CNT     = op_cnt_q;

endmodule

// File: tb/tb_fu_arbiter.sv
// Bench for fu_arbiter: stand-in function unit, transaction-level model checked every
// cycle on the falling edge, plus directed scenarios with hand-computed responses.
module tb_fu_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       v0 = 1'b0, v1 = 1'b0;
   logic [4:0] fs0 = '0, fs1 = '0;
   logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic       rsp_ready = 1'b1;
   logic       rdy0, rdy1;
   logic [4:0] fu_fs;
   logic [7:0] fu_a, fu_b, fu_f;
   logic       fu_v, fu_c, fu_n, fu_z;
   logic       rsp_valid, rsp_id, rsp_err, busy;
   logic [7:0] rsp_f, op_cnt;
   logic [3:0] rsp_flags;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   fu_arbiter #(.DW(8)) dut (
      .CLK(clk), .RST_N(rst_n),
      .REQ0_VALID(v0), .REQ0_READY(rdy0), .REQ0_FS(fs0), .REQ0_A(a0), .REQ0_B(b0),
      .REQ1_VALID(v1), .REQ1_READY(rdy1), .REQ1_FS(fs1), .REQ1_A(a1), .REQ1_B(b1),
      .FU_FS(fu_fs), .FU_A(fu_a), .FU_B(fu_b),
      .FU_F(fu_f), .FU_V(fu_v), .FU_C(fu_c), .FU_N(fu_n), .FU_Z(fu_z),
      .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_ID(rsp_id),
      .RSP_F(rsp_f), .RSP_FLAGS(rsp_flags), .RSP_ERR(rsp_err),
      .BUSY(busy), .OP_CNT(op_cnt)
   );

   // Arithmetic codes 0-7 follow A + {0|B|~B|FF} + fs[0]; illegal codes give junk on purpose.
   function automatic logic [11:0] fu_calc(input logic [4:0] fs, input logic [7:0] a,
                                           input logic [7:0] b);
      logic [7:0] bb, f;
      logic [8:0] s;
      logic       v, c;
      v = 1'b0;
      c = 1'b0;
      f = 8'h00;
      if (fs < 5'd8) begin
         case (fs[2:1])
            2'd0:    bb = 8'h00;
            2'd1:    bb = b;
            2'd2:    bb = ~b;
            default: bb = 8'hFF;
         endcase
         s = {1'b0, a} + {1'b0, bb} + {8'd0, fs[0]};
         f = s[7:0];
         c = s[8];
         v = (a[7] == bb[7]) && (f[7] != a[7]);
      end else begin
         case (fs)
            5'd8:    f = a & b;
            5'd10:   f = a | b;
            5'd12:   f = a ^ b;
            5'd14:   f = ~a;
            5'd16:   f = b;
            5'd20:   f = b >> 1;
            5'd24:   f = b << 1;
            default: return {a ^ 8'hA5, 4'b1111};
         endcase
      end
      return {f, v, c, f[7], (f == 8'h00)};
   endfunction

   assign {fu_f, fu_v, fu_c, fu_n, fu_z} = fu_calc(fu_fs, fu_a, fu_b);

   function automatic bit is_legal(input logic [4:0] fs);
      return (fs inside {[5'd0:5'd8], 5'd10, 5'd12, 5'd14, 5'd16, 5'd20, 5'd24});
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_err++;
      $display("FAIL %s: timed out at %0t", name, $time);
   endtask

   // Transaction model: an op is either absent, executing, or holding a response.
   bit         m_busy = 0, m_resp = 0, m_pri = 0, m_id = 0;
   logic [4:0] m_fs = '0;
   logic [7:0] m_a = '0, m_b = '0;
   bit         m_rid = 0, m_rerr = 0;
   logic [7:0] m_rf = '0;
   logic [3:0] m_rfl = '0;
   logic [7:0] m_cnt = '0;

   always @(negedge clk) begin
      bit         e0, e1;
      logic [11:0] r;
      e0 = rst_n && !m_busy && v0 && (!v1 || !m_pri);
      e1 = rst_n && !m_busy && v1 && (!v0 || m_pri);
      chk("req0_ready", rdy0, e0);
      chk("req1_ready", rdy1, e1);
      chk("busy", busy, m_busy);
      chk("rsp_valid", rsp_valid, m_resp);
      chk("rsp_id", rsp_id, m_rid);
      chk("rsp_f", rsp_f, m_rf);
      chk("rsp_flags", rsp_flags, m_rfl);
      chk("rsp_err", rsp_err, m_rerr);
      chk("fu_fs", fu_fs, m_fs);
      chk("fu_a", fu_a, m_a);
      chk("fu_b", fu_b, m_b);
      chk("op_cnt", op_cnt, m_cnt);

      if (!rst_n) begin
         m_busy = 0; m_resp = 0; m_pri = 0; m_id = 0;
         m_fs = '0; m_a = '0; m_b = '0;
         m_rid = 0; m_rf = '0; m_rfl = '0; m_rerr = 0; m_cnt = '0;
      end else if (!m_busy) begin
         if (e0 || e1) begin
            m_busy = 1;
            m_id   = e1;
            m_fs   = e1 ? fs1 : fs0;
            m_a    = e1 ? a1 : a0;
            m_b    = e1 ? b1 : b0;
         end
      end else if (!m_resp) begin
         r      = fu_calc(m_fs, m_a, m_b);
         m_rid  = m_id;
         m_rerr = !is_legal(m_fs);
         m_rf   = m_rerr ? 8'h00 : r[11:4];
         m_rfl  = m_rerr ? 4'h0 : r[3:0];
         m_resp = 1;
      end else if (rsp_ready) begin
         m_busy = 0;
         m_resp = 0;
         m_pri  = !m_rid;
         m_cnt  = m_cnt + 8'd1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      v0 = 1'b0;
      v1 = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   task automatic issue(input bit r, input logic [4:0] fs, input logic [7:0] a,
                        input logic [7:0] b);
      bit got = 0;
      if (r) begin fs1 = fs; a1 = a; b1 = b; v1 = 1'b1; end
      else   begin fs0 = fs; a0 = a; b0 = b; v0 = 1'b1; end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (r ? rdy1 : rdy0) begin got = 1; break; end
      end
      tick();
      if (r) v1 = 1'b0; else v0 = 1'b0;
      if (!got) fail_now("grant_wait");
   endtask

   task automatic wait_rsp(input bit id, input logic [7:0] f, input logic [3:0] fl,
                           input bit err, input bit lit_on);
      bit got = 0;
      int n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) begin got = 1; n = i; break; end
      end
      if (!got) fail_now("rsp_wait");
      else if (lit_on) begin
         chk("lit_latency", n, 1);
         chk("lit_id", rsp_id, id);
         chk("lit_f", rsp_f, f);
         chk("lit_flags", rsp_flags, fl);
         chk("lit_err", rsp_err, err);
      end
      tick();
   endtask

   initial begin
      // Reset, with a pending request that must not be acknowledged.
      v0 = 1'b1;
      repeat (2) tick();
      @(negedge clk);
      chk("lit_rst_ready0", rdy0, 1'b0);
      tick();
      do_reset();

      // Single op.
      issue(0, 5'd2, 8'h0A, 8'h0A);
      wait_rsp(0, 8'h14, 4'b0000, 0, 1);
      chk("lit_cnt_single", op_cnt, 8'd1);

      // Contention after reset.
      do_reset();
      fs1 = 5'd8; a1 = 8'hFF; b1 = 8'h0A; v1 = 1'b1;
      issue(0, 5'd2, 8'h80, 8'h80);
      wait_rsp(0, 8'h00, 4'b1101, 0, 1);
      issue(1, 5'd8, 8'hFF, 8'h0A);
      wait_rsp(1, 8'h0A, 4'b0000, 0, 1);
      v0 = 1'b1; v1 = 1'b1;
      @(negedge clk);
      chk("lit_third_ready0", rdy0, 1'b1);
      chk("lit_third_ready1", rdy1, 1'b0);
      tick();
      v0 = 1'b0; v1 = 1'b0;
      wait_rsp(0, 8'h00, 4'b1101, 0, 1);

      // Backpressure; the held response stalls both requesters.
      rsp_ready = 1'b0;
      issue(0, 5'd3, 8'h01, 8'h02);
      wait_rsp(0, 8'h04, 4'b0000, 0, 1);
      fs1 = 5'd12; a1 = 8'hF0; b1 = 8'h0F;
      v0 = 1'b1; v1 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("lit_bp_busy", busy, 1'b1);
         chk("lit_bp_rdy", {rdy0, rdy1}, 2'b00);
         chk("lit_bp_f", rsp_f, 8'h04);
      end
      tick();
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("lit_bp_cnt_before", op_cnt, 8'd3);
      tick();
      @(negedge clk);
      chk("lit_bp_cnt_after", op_cnt, 8'd4);
      chk("lit_bp_next_ready1", rdy1, 1'b1);
      tick();
      v0 = 1'b0; v1 = 1'b0;
      wait_rsp(1, 8'hFF, 4'b0010, 0, 1);

      // Illegal function select.
      issue(1, 5'd9, 8'h33, 8'h11);
      wait_rsp(1, 8'h00, 4'b0000, 1, 1);
      chk("lit_cnt_illegal", op_cnt, 8'd6);

      // Reset while executing discards the op and the priority pointer.
      issue(1, 5'd2, 8'h01, 8'h01);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("lit_midrst_valid", rsp_valid, 1'b0);
         chk("lit_midrst_cnt", op_cnt, 8'd0);
      end
      tick();
      fs1 = 5'd2; a1 = 8'h05; b1 = 8'h06;
      v0 = 1'b1; v1 = 1'b1;
      fs0 = 5'd1; a0 = 8'h7F; b0 = 8'h00;
      @(negedge clk);
      chk("lit_midrst_pri", rdy0, 1'b1);
      tick();
      v0 = 1'b0; v1 = 1'b0;
      wait_rsp(0, 8'h80, 4'b1010, 0, 1);

      // Shifts.
      issue(0, 5'd24, 8'h00, 8'h55);
      wait_rsp(0, 8'hAA, 4'b0010, 0, 1);
      issue(1, 5'd20, 8'h00, 8'h55);
      wait_rsp(1, 8'h2A, 4'b0000, 0, 1);

      // Counter wrap.
      do_reset();
      for (int k = 0; k < 256; k++) begin
         issue(k[0], 5'(k % 25), 8'(k), 8'(k * 3));
         wait_rsp(0, 8'h00, 4'h0, 0, 0);
         if (k == 254) chk("lit_cnt_255", op_cnt, 8'd255);
      end
      chk("lit_cnt_wrap", op_cnt, 8'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end

endmodule
